booth_mult_sequencer: RTL and testbench

Control-and-register block that runs a full 32×32 signed multiply by iterating the team's radix-2 Booth step datapath 32 times. It captures the operands on a start pulse and owns the 65-bit partial-product register. It feeds the step unit one cycle per iteration and returns the low 32 product bits with an overflow flag and a one-cycle ready pulse. It sits inside the multdiv unit between the processor's multiply control strobe and the combinational Booth step.

---
 rtl/booth_mult_sequencer_if.sv | 29 ++
 rtl/booth_mult_sequencer.sv | 79 +++++++
 tb/tb_booth_mult_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_sequencer_if.sv
// Bus between the multiply sequencer, its requester and the combinational
// Booth step unit. The master side is the requester plus step unit; the
// slave side is the sequencer.
interface booth_mult_sequencer_if;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [64:0] step_in;
    logic [31:0] step_multiplicand;
    logic [31:0] step_multiplier;
    logic [64:0] step_out;
    logic        step_exception;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_mult, data_operandA, data_operandB, step_out, step_exception,
        input  step_in, step_multiplicand, step_multiplier,
               data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_mult, data_operandA, data_operandB, step_out, step_exception,
        output step_in, step_multiplicand, step_multiplier,
               data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_mult_sequencer.sv
// Sequencer for a 32x32 signed radix-2 Booth multiply. Owns the 65-bit
// {hi, lo, q_1} partial-product register and iterates an external
// combinational step unit once per cycle, then publishes the low product
// word with the final-step overflow flag and a one-cycle ready pulse.
module booth_mult_sequencer #(
    parameter int ITERATIONS = 32
) (
    input logic                  clock,
    input logic                  reset_n,
    booth_mult_sequencer_if.slave bus
);
    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [64:0]      acc;
    logic [31:0]      mcand;
    logic [31:0]      mplier;
    logic [CNT_W-1:0] count;
    logic [31:0]      result;
    logic             exc;
    logic             last_step;

    assign last_step = (count == LAST);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: a start strobe always (re)enters RUN, even mid-operation.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ctrl_mult) state_nxt = RUN;
            RUN:     if (bus.ctrl_mult) state_nxt = RUN;
                     else if (last_step) state_nxt = DONE;
            DONE:    state_nxt = bus.ctrl_mult ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, partial-product iteration and result latch. A start
    // wins over the final step, so an aborted operation never publishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
            exc    <= 1'b0;
        end else if (bus.ctrl_mult) begin
            mcand  <= bus.data_operandA;
            mplier <= bus.data_operandB;
            acc    <= {32'b0, bus.data_operandB, 1'b0};
            count  <= '0;
        end else if (state == RUN) begin
            acc   <= bus.step_out;
            count <= last_step ? '0 : count + 1'b1;
            if (last_step) begin
                result <= bus.step_out[32:1];
                exc    <= bus.step_exception;
            end
        end
    end

    // Everything seen by the step unit and the requester comes from flops.
    assign bus.step_in           = acc;
    assign bus.step_multiplicand = mcand;
    assign bus.step_multiplier   = mplier;
    assign bus.data_result       = result;
    assign bus.data_exception    = exc;
    assign bus.data_resultRDY    = (state == DONE);
    assign bus.busy              = (state == RUN);
endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: supplies a behavioural radix-2 Booth step
// unit, runs a table of directed multiplies and then the abort, mid-op
// reset and back-to-back sequences.
module tb_booth_mult_sequencer;
    logic clock;
    logic reset_n;
    booth_mult_sequencer_if bus ();

    booth_mult_sequencer #(.ITERATIONS(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Booth step: add/sub multiplicand into a sign-extended hi, then shift
    // the whole {hi, lo, q_1} right by one. Overflow flags a running product
    // that no longer fits in 32 signed bits.
    logic [32:0] hx;
    always_comb begin
        hx = {bus.step_in[64], bus.step_in[64:33]};
        case (bus.step_in[1:0])
            2'b01:   hx = hx + {bus.step_multiplicand[31], bus.step_multiplicand};
            2'b10:   hx = hx - {bus.step_multiplicand[31], bus.step_multiplicand};
            default: hx = hx;
        endcase
        bus.step_out       = {hx, bus.step_in[32:1]};
        bus.step_exception = (bus.step_out[64:33] != {32{bus.step_out[32]}});
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a one-cycle start strobe; returns at the negedge after E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_mult     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_mult     = 1'b0;
    endtask

    // Count negedges until ready, bounded.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!bus.data_resultRDY && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    vec_t vecs[7];
    int   lat;
    logic seen;

    initial begin
        vecs[0] = '{32'h00000003, 32'h00000005, 32'h0000000F, 1'b0};
        vecs[1] = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0};
        vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0};
        vecs[5] = '{32'h00000000, 32'h12345678, 32'h00000000, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};

        reset_n           = 1'b0;
        bus.ctrl_mult     = 1'b0;
        bus.data_operandA = 32'h0;
        bus.data_operandB = 32'h0;

        // Reset state.
        #1;
        check("rst_result", bus.data_result, 0);
        check("rst_exc",    bus.data_exception, 0);
        check("rst_rdy",    bus.data_resultRDY, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_stepin", bus.step_in, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (bus.data_resultRDY || bus.busy) seen = 1'b1;
        end
        check("idle_quiet", seen, 0);

        // Table of directed multiplies.
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), bus.busy, 1);
            check($sformatf("v%0d_mcand", i), bus.step_multiplicand, vecs[i].a);
            wait_ready(lat);
            check($sformatf("v%0d_lat", i), lat, 32);
            check($sformatf("v%0d_res", i), bus.data_result, vecs[i].res);
            check($sformatf("v%0d_exc", i), bus.data_exception, vecs[i].exc);
            check($sformatf("v%0d_busy_done", i), bus.busy, 0);
            @(negedge clock);
            check($sformatf("v%0d_rdy_drop", i), bus.data_resultRDY, 0);
        end

        // Abort/restart: the second start at cycle 10 replaces the first.
        start_op(32'd2, 32'd2);
        seen = 1'b0;
        repeat (9) begin
            @(negedge clock);
            if (bus.data_resultRDY) seen = 1'b1;
        end
        start_op(32'd4, 32'd5);
        repeat (20) begin
            @(negedge clock);
            if (bus.data_resultRDY) seen = 1'b1;
        end
        check("abort_no_early_rdy", seen, 0);
        check("abort_held_res", bus.data_result, 32'h00000001);
        check("abort_busy", bus.busy, 1);
        wait_ready(lat);
        check("abort_lat", lat + 20, 32);
        check("abort_res", bus.data_result, 32'h00000014);
        check("abort_exc", bus.data_exception, 0);

        // Mid-operation reset discards everything.
        start_op(32'd9, 32'd9);
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mrst_busy",   bus.busy, 0);
        check("mrst_res",    bus.data_result, 0);
        check("mrst_exc",    bus.data_exception, 0);
        check("mrst_rdy",    bus.data_resultRDY, 0);
        check("mrst_stepin", bus.step_in, 0);
        check("mrst_mcand",  bus.step_multiplicand, 0);
        check("mrst_mplier", bus.step_multiplier, 0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY || bus.busy) seen = 1'b1;
        end
        check("mrst_no_rdy", seen, 0);
        start_op(32'd9, 32'd9);
        wait_ready(lat);
        check("mrst_redo_lat", lat, 32);
        check("mrst_redo_res", bus.data_result, 32'h00000051);

        // Back-to-back: start again during the ready cycle.
        @(negedge clock);
        start_op(32'd1, 32'd1);
        wait_ready(lat);
        check("b2b_lat1", lat, 32);
        check("b2b_res1", bus.data_result, 32'h00000001);
        check("b2b_exc1", bus.data_exception, 0);
        bus.ctrl_mult     = 1'b1;
        bus.data_operandA = 32'hFFFFFFFF;
        bus.data_operandB = 32'hFFFFFFFF;
        @(negedge clock);
        bus.ctrl_mult     = 1'b0;
        check("b2b_rdy_drop", bus.data_resultRDY, 0);
        check("b2b_busy", bus.busy, 1);
        wait_ready(lat);
        check("b2b_lat2", lat, 32);
        check("b2b_res2", bus.data_result, 32'h00000001);
        check("b2b_exc2", bus.data_exception, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
